mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences the single shared memory port of the multicycle datapath.
//  - Arbitrates between three requesters: instruction fetch, data load/store, exception-vector read.
//  - Drives the 3-bit IorD address-mux select and the memory write strobe.
//  - Holds the select stable for the memory latency, then pulses a per-requester done.
//  - Sits between the main control FSM and the address mux / memory.
// PARAMETERS
//  MEM_LAT       2  memory cycles from address valid to read data valid; legal 1..15
//  FETCH_STARVE  4  max consecutive data grants while fetch_req is pending; legal 1..15
// PORTS
//  clk         in   1  single clock, rising edge
//  reset_n     in   1  synchronous reset, active low
//  fetch_req   in   1  fetch request, address = PC
//  data_req    in   1  load/store request
//  data_we     in   1  1 = store, 0 = load; sampled at grant
//  data_src    in   2  address source, sampled at grant:
//                      00 ALUOut, 01 Reg_A, 10 Reg_B, 11 RES
//  exc_req     in   1  exception-vector read, address = Excpt
//  iord_sel    out  3  mux select: 000 PC, 001 RES, 010 ALUOut, 011 Excpt, 100 Reg_A, 101 Reg_B
//  mem_wr      out  1  memory write strobe
//  busy        out  1  high in ACCESS and DONE
//  fetch_done  out  1  one-cycle pulse, fetch access complete
//  data_done   out  1  one-cycle pulse, data access complete
//  exc_done    out  1  one-cycle pulse, exception read complete
// BEHAVIOUR
//  - Reset (reset_n=0 at a rising edge):
//    - state=IDLE, iord_sel=000, mem_wr=0, busy=0, all done=0, counters=0.
//    - Overrides everything, including mid-access: the transaction is dropped and no done is issued.
//  - FSM states: IDLE, ACCESS, DONE. All outputs are registered.
//  - IDLE, no request: iord_sel=000. When any req=1:
//    - grant by priority: exc > data > fetch.
//    - exception: fetch beats data if fetch_req=1 and starve_cnt==FETCH_STARVE.
//    - latch owner, data_we and data_src; load lat_cnt=MEM_LAT-1; go to ACCESS.
//  - ACCESS:
//    - iord_sel is fixed by the owner: fetch=000, exc=011, data maps per data_src.
//    - mem_wr=1 only in the first ACCESS cycle, and only when owner=data and data_we=1.
//    - lat_cnt decrements each cycle; at 0 go to DONE. ACCESS therefore lasts exactly MEM_LAT cycles.
//  - DONE (one cycle):
//    - iord_sel held, mem_wr=0, owner's done=1.
//    - Next state is always IDLE, so back-to-back accesses are spaced MEM_LAT+2 cycles apart.
//  - Latency: req seen in IDLE at edge N -> done high during cycle N+MEM_LAT+1.
//  - Handshake:
//    - A requester holds req high until its done pulse and drops it the cycle after.
//    - req still high in the IDLE cycle after done is treated as a new request.
//    - req deasserted while owned is ignored; the access completes.
//    - data_we and data_src changes after grant are ignored.
//  - starve_cnt (4 bits, saturating at FETCH_STARVE):
//    - +1 on each data grant made while fetch_req=1.
//    - cleared on each fetch grant.
//    - unchanged on exc grants.
//  - Simultaneous requests: exactly one grant per IDLE cycle; losers wait and are never dropped.
//  - Inputs are not sampled in ACCESS or DONE.
// TESTING
//  1. Reset, then fetch_req=1 at edge 0, MEM_LAT=2:
//     -> iord_sel=000 in cycles 1-2; fetch_done=1 in cycle 3 only; mem_wr stays 0.
//  2. Store: data_req=1, data_we=1, data_src=10:
//     -> iord_sel=101 for 3 cycles; mem_wr=1 in first ACCESS cycle only; data_done=1 in DONE cycle.
//  3. exc_req, data_req, fetch_req all high together:
//     -> grant order exc (011), then data, then fetch; each done pulses exactly once.
//  4. fetch_req and data_req held high continuously, FETCH_STARVE=4:
//     -> 4 data grants, then 1 fetch grant, pattern repeats.
//  5. reset_n=0 in the middle of an ACCESS cycle:
//     -> next cycle all outputs at reset values, no done pulse.
//  6. data_src sweep 00/01/10/11 on loads:
//     -> iord_sel = 010/100/101/001 respectively; mem_wr never asserted.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Sequences the single shared memory port of the multicycle datapath.
//   It arbitrates between instruction fetch, data load/store and
//   exception-vector read. It then holds the address-mux select for the memory
//   latency and pulses a done for the requester that owns the access.
//   All outputs are registered.
//
// Parameters
//   MEM_LAT       memory cycles from address valid to read data valid (1..15)
//   FETCH_STARVE  max consecutive data grants while fetch_req is pending (1..15)
//
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   synchronous reset, active low
//   fetch_req   in   fetch request (address = PC)
//   data_req    in   load/store request
//   data_we     in   1 = store, 0 = load; sampled at grant
//   data_src    in   data address source, sampled at grant:
//                    00 ALUOut, 01 Reg_A, 10 Reg_B, 11 RES
//   exc_req     in   exception-vector read (address = Excpt)
//   iord_sel    out  address mux select:
//                    000 PC, 001 RES, 010 ALUOut, 011 Excpt, 100 Reg_A, 101 Reg_B
//   mem_wr      out  memory write strobe, first ACCESS cycle of a store only
//   busy        out  high in ACCESS and DONE
//   fetch_done  out  one-cycle pulse, fetch access complete
//   data_done   out  one-cycle pulse, data access complete
//   exc_done    out  one-cycle pulse, exception read complete
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int MEM_LAT      = 2,
  parameter int FETCH_STARVE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       fetch_req,
  input  logic       data_req,
  input  logic       data_we,
  input  logic [1:0] data_src,
  input  logic       exc_req,
  output logic [2:0] iord_sel,
  output logic       mem_wr,
  output logic       busy,
  output logic       fetch_done,
  output logic       data_done,
  output logic       exc_done
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;
  typedef enum logic [1:0] {OWN_FETCH, OWN_DATA, OWN_EXC} owner_e;

  localparam logic [2:0] SEL_PC    = 3'b000;
  localparam logic [2:0] SEL_RES   = 3'b001;
  localparam logic [2:0] SEL_ALU   = 3'b010;
  localparam logic [2:0] SEL_EXC   = 3'b011;
  localparam logic [2:0] SEL_REG_A = 3'b100;
  localparam logic [2:0] SEL_REG_B = 3'b101;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(FETCH_STARVE);

  function automatic logic [2:0] src_to_sel(input logic [1:0] src);
    case (src)
      2'b00:   return SEL_ALU;
      2'b01:   return SEL_REG_A;
      2'b10:   return SEL_REG_B;
      default: return SEL_RES;
    endcase
  endfunction

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [3:0] lat_cnt_q, lat_cnt_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic [2:0] iord_sel_q, iord_sel_d;
  logic       mem_wr_q, mem_wr_d;
  logic       busy_q, busy_d;
  logic       fetch_done_q, fetch_done_d;
  logic       data_done_q, data_done_d;
  logic       exc_done_q, exc_done_d;

  // Fetch overrides data once data has won FETCH_STARVE times in a row
  // while fetch was waiting.
  logic fetch_forced;
  assign fetch_forced = fetch_req && (starve_cnt_q == STARVE_MAX);

  // Every _d computed here is the registered output value for the NEXT cycle.
  // data_we and data_src are captured at grant as mem_wr_q and iord_sel_q, so
  // later changes on those inputs have no effect on the running access.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    iord_sel_d   = iord_sel_q;
    mem_wr_d     = 1'b0;
    busy_d       = busy_q;
    fetch_done_d = 1'b0;
    data_done_d  = 1'b0;
    exc_done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        iord_sel_d = SEL_PC;
        busy_d     = 1'b0;
        if (exc_req || data_req || fetch_req) begin
          state_d   = S_ACCESS;
          busy_d    = 1'b1;
          lat_cnt_d = LAT_INIT;
          if (exc_req) begin
            owner_d    = OWN_EXC;
            iord_sel_d = SEL_EXC;
          end else if (data_req && !fetch_forced) begin
            owner_d    = OWN_DATA;
            iord_sel_d = src_to_sel(data_src);
            mem_wr_d   = data_we;
            if (fetch_req && (starve_cnt_q < STARVE_MAX)) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
          end else begin
            // Only fetch can be left here: no exc, and data either absent or
            // overridden by a starving fetch.
            owner_d      = OWN_FETCH;
            iord_sel_d   = SEL_PC;
            starve_cnt_d = 4'd0;
          end
        end
      end

      S_ACCESS: begin
        if (lat_cnt_q == 4'd0) begin
          state_d      = S_DONE;
          fetch_done_d = (owner_q == OWN_FETCH);
          data_done_d  = (owner_q == OWN_DATA);
          exc_done_d   = (owner_q == OWN_EXC);
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        iord_sel_d = SEL_PC;
      end

      default: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        iord_sel_d = SEL_PC;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_FETCH;
      lat_cnt_q    <= 4'd0;
      starve_cnt_q <= 4'd0;
      iord_sel_q   <= SEL_PC;
      mem_wr_q     <= 1'b0;
      busy_q       <= 1'b0;
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;
      exc_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      iord_sel_q   <= iord_sel_d;
      mem_wr_q     <= mem_wr_d;
      busy_q       <= busy_d;
      fetch_done_q <= fetch_done_d;
      data_done_q  <= data_done_d;
      exc_done_q   <= exc_done_d;
    end
  end

  assign iord_sel   = iord_sel_q;
  assign mem_wr     = mem_wr_q;
  assign busy       = busy_q;
  assign fetch_done = fetch_done_q;
  assign data_done  = data_done_q;
  assign exc_done   = exc_done_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Self-checking bench for mem_access_ctrl. Outputs are packed for comparison
//   as {iord_sel[2:0], mem_wr, busy, fetch_done, data_done, exc_done}.
//   The reference model treats each grant as a fixed schedule of output
//   vectors (MEM_LAT access cycles, one done cycle, one idle cycle) that is
//   queued up when the grant happens.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int MEM_LAT      = 2;
  localparam int FETCH_STARVE = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fetch_req, data_req, data_we, exc_req;
  logic [1:0] data_src;
  logic [2:0] iord_sel;
  logic       mem_wr, busy, fetch_done, data_done, exc_done;

  int checks   = 0;
  int failures = 0;

  mem_access_ctrl #(.MEM_LAT(MEM_LAT), .FETCH_STARVE(FETCH_STARVE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fetch_req  (fetch_req),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_src   (data_src),
    .exc_req    (exc_req),
    .iord_sel   (iord_sel),
    .mem_wr     (mem_wr),
    .busy       (busy),
    .fetch_done (fetch_done),
    .data_done  (data_done),
    .exc_done   (exc_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string      name;
    logic       f;
    logic       d;
    logic       we;
    logic [1:0] src;
    logic       e;
    logic [2:0] sel;
    logic       wr;
    logic [2:0] done;   // {fetch, data, exc}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] outs();
    return {iord_sel, mem_wr, busy, fetch_done, data_done, exc_done};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b (sel,wr,busy,fd,dd,ed)", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic d, input logic we,
                       input logic [1:0] src, input logic e);
    fetch_req = f;
    data_req  = d;
    data_we   = we;
    data_src  = src;
    exc_req   = e;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    check("reset", outs(), 8'h00);
    reset_n = 1'b1;
  endtask

  // Address map for data accesses, taken from the port description.
  function automatic logic [2:0] model_src_sel(input logic [1:0] src);
    logic [2:0] map [4];
    map[0] = 3'b010;  // ALUOut
    map[1] = 3'b100;  // Reg_A
    map[2] = 3'b101;  // Reg_B
    map[3] = 3'b001;  // RES
    return map[src];
  endfunction

  logic [2:0] grants[$];
  logic [7:0] exp_v;

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

    //            name        f     d     we    src    e     sel     wr    done
    vecs.push_back('{"fetch",    1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 3'b100});
    vecs.push_back('{"store_b",  1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 3'b101, 1'b1, 3'b010});
    vecs.push_back('{"load_alu", 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3'b010, 1'b0, 3'b010});
    vecs.push_back('{"load_a",   1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 3'b100, 1'b0, 3'b010});
    vecs.push_back('{"load_b",   1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 3'b101, 1'b0, 3'b010});
    vecs.push_back('{"load_res", 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 3'b001, 1'b0, 3'b010});
    vecs.push_back('{"exc",      1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'b011, 1'b0, 3'b001});
    vecs.push_back('{"store_res",1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 3'b001, 1'b1, 3'b010});

    // ---- Single accesses from the table --------------------------------
    do_reset();
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].f, vecs[i].d, vecs[i].we, vecs[i].src, vecs[i].e);
      for (int c = 1; c <= MEM_LAT + 1; c++) begin
        @(negedge clk);
        exp_v = {vecs[i].sel, (c == 1) ? vecs[i].wr : 1'b0, 1'b1,
                 (c == MEM_LAT + 1) ? vecs[i].done : 3'b000};
        check($sformatf("%s_c%0d", vecs[i].name, c), outs(), exp_v);
        if (c == 1) begin
          // Changes after grant must not disturb the running access.
          data_we  = ~data_we;
          data_src = ~data_src;
        end
        if (c == MEM_LAT + 1) drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
      end
      @(negedge clk);
      check($sformatf("%s_idle", vecs[i].name), outs(), 8'h00);
    end

    // ---- All three requesters at once: exc, data, fetch ----------------
    begin
      int n_fd, n_dd, n_ed;
      logic prev_busy;
      n_fd = 0; n_dd = 0; n_ed = 0; prev_busy = 1'b0;
      grants.delete();
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
      for (int cyc = 0; cyc < 3 * (MEM_LAT + 2) + 3; cyc++) begin
        @(negedge clk);
        if (busy && !prev_busy) grants.push_back(iord_sel);
        prev_busy = busy;
        if (fetch_done) begin n_fd++; fetch_req = 1'b0; end
        if (data_done)  begin n_dd++; data_req  = 1'b0; end
        if (exc_done)   begin n_ed++; exc_req   = 1'b0; end
      end
      check("tri_ngrants", 8'(grants.size()), 8'd3);
      check("tri_g0", {5'd0, (grants.size() > 0) ? grants[0] : 3'b111}, 8'b011);
      check("tri_g1", {5'd0, (grants.size() > 1) ? grants[1] : 3'b111}, 8'b010);
      check("tri_g2", {5'd0, (grants.size() > 2) ? grants[2] : 3'b111}, 8'b000);
      check("tri_fdone", 8'(n_fd), 8'd1);
      check("tri_ddone", 8'(n_dd), 8'd1);
      check("tri_edone", 8'(n_ed), 8'd1);
    end

    // ---- Fetch starvation: fetch and data both held high ---------------
    begin
      logic prev_busy;
      logic [2:0] exp_sel;
      prev_busy = 1'b0;
      grants.delete();
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
      for (int cyc = 0; cyc < 10 * (MEM_LAT + 2) + 5 && grants.size() < 10; cyc++) begin
        @(negedge clk);
        if (busy && !prev_busy) grants.push_back(iord_sel);
        prev_busy = busy;
      end
      check("starve_ngrants", 8'(grants.size()), 8'd10);
      for (int g = 0; g < 10; g++) begin
        exp_sel = ((g % (FETCH_STARVE + 1)) == FETCH_STARVE) ? 3'b000 : 3'b010;
        check($sformatf("starve_g%0d", g),
              {5'd0, (grants.size() > g) ? grants[g] : 3'b111}, {5'd0, exp_sel});
      end
    end

    // ---- Reset in the middle of an access ------------------------------
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
    @(negedge clk);
    check("rst_mid_access", outs(), {3'b100, 1'b1, 1'b1, 3'b000});
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_reset", outs(), 8'h00);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    for (int c = 0; c < MEM_LAT + 2; c++) begin
      @(negedge clk);
      check($sformatf("rst_mid_quiet%0d", c), outs(), 8'h00);
    end

    // ---- Randomized run against the schedule model ---------------------
    begin
      logic [7:0] sched[$];
      logic [7:0] exp_cur;
      int         starve;
      bit         fp, dp, ep;
      logic       we;
      logic [1:0] src;
      logic [2:0] sel, done;
      logic       wr;
      do_reset();
      exp_cur = 8'h00;
      starve  = 0;
      fp = 0; dp = 0; ep = 0;
      for (int n = 0; n < 3000; n++) begin
        @(negedge clk);
        check($sformatf("rand_%0d", n), outs(), exp_cur);

        // Requesters hold until their done, then usually drop.
        if (exp_cur[2]) fp = ($urandom_range(0, 3) == 0);
        else if (!fp)   fp = ($urandom_range(0, 9) < 3);
        if (exp_cur[1]) dp = ($urandom_range(0, 3) == 0);
        else if (!dp)   dp = ($urandom_range(0, 9) < 4);
        if (exp_cur[0]) ep = ($urandom_range(0, 3) == 0);
        else if (!ep)   ep = ($urandom_range(0, 19) == 0);
        we  = 1'($urandom_range(0, 1));
        src = 2'($urandom_range(0, 3));
        drive(fp, dp, we, src, ep);
        reset_n = ($urandom_range(0, 199) != 0);

        // Model of the coming edge.
        if (!reset_n) begin
          sched.delete();
          starve  = 0;
          exp_cur = 8'h00;
        end else if (sched.size() > 0) begin
          exp_cur = sched.pop_front();
        end else if (fp || dp || ep) begin
          wr = 1'b0;
          if (ep) begin
            sel = 3'b011; done = 3'b001;
          end else if (dp && !(fp && starve == FETCH_STARVE)) begin
            sel = model_src_sel(src); done = 3'b010; wr = we;
            if (fp && starve < FETCH_STARVE) starve = starve + 1;
          end else begin
            sel = 3'b000; done = 3'b100; starve = 0;
          end
          for (int i = 0; i < MEM_LAT; i++)
            sched.push_back({sel, (i == 0) ? wr : 1'b0, 1'b1, 3'b000});
          sched.push_back({sel, 1'b0, 1'b1, done});
          sched.push_back(8'h00);
          exp_cur = sched.pop_front();
        end else begin
          exp_cur = 8'h00;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
